// File: rtl/pcm_frame_packer.sv
// Frames the per-mic PCM FIFO heads into sync, seq, samples and checksum bytes for the SPI slave.
// One byte is loaded per data_needed rising edge, on the edge that detects it; ssel edges restart or abort the frame.
module pcm_frame_packer #(
  parameter int         NUM_MICS   = 9,
  parameter int         BIT_WIDTH  = 8,
  parameter logic [7:0] FRAME_SYNC = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ssel,
  input  logic                          data_needed,
  input  logic [NUM_MICS-1:0]           fifo_rdempty,
  input  logic [NUM_MICS*BIT_WIDTH-1:0] fifo_q,
  output logic [NUM_MICS-1:0]           fifo_rdreq,
  output logic [7:0]                    data_to_send,
  output logic [NUM_MICS-1:0]           underrun,
  output logic                          frame_done
);

  localparam int BPS = (BIT_WIDTH <= 8) ? 1 : 2;
  localparam int SW  = 8 * BPS;
  localparam int MW  = (NUM_MICS > 1) ? $clog2(NUM_MICS) : 1;
  localparam logic [MW-1:0] LAST_MIC  = MW'(NUM_MICS - 1);
  localparam logic          LAST_BIDX = 1'(BPS - 1);

  // ST_SYNC is the slot after the checksum: its edge re-sends FRAME_SYNC.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEQ,
    ST_DATA,
    ST_CHK,
    ST_SYNC
  } state_t;

  state_t              state_q, state_d;
  logic [MW-1:0]       mic_q, mic_d;
  logic                bidx_q, bidx_d;
  logic [SW-1:0]       snap_q, snap_d;
  logic                snap_vld_q, snap_vld_d;
  logic [7:0]          csum_q, csum_d;
  logic [7:0]          seq_q, seq_d;
  logic [7:0]          dout_q, dout_d;
  logic [NUM_MICS-1:0] rdreq_q, rdreq_d;
  logic [NUM_MICS-1:0] underrun_q, underrun_d;
  logic                done_q, done_d;

  logic ssel_s1_q, ssel_s2_q, ssel_s3_q;
  logic dn_q;
  logic sync_fall, sync_rise, dn_edge;

  logic [SW-1:0] head_ext;
  logic [SW-1:0] cur_snap;
  logic          head_empty;
  logic          cur_vld;
  logic [7:0]    out_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssel_s1_q <= 1'b1;
      ssel_s2_q <= 1'b1;
      ssel_s3_q <= 1'b1;
      dn_q      <= 1'b0;
    end else begin
      ssel_s1_q <= ssel;
      ssel_s2_q <= ssel_s1_q;
      ssel_s3_q <= ssel_s2_q;
      dn_q      <= data_needed;
    end
  end

  assign sync_fall = ssel_s3_q & ~ssel_s2_q;
  assign sync_rise = ~ssel_s3_q & ssel_s2_q;
  assign dn_edge   = data_needed & ~dn_q;

  always_comb begin
    state_d    = state_q;
    mic_d      = mic_q;
    bidx_d     = bidx_q;
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;
    csum_d     = csum_q;
    seq_d      = seq_q;
    dout_d     = dout_q;
    underrun_d = underrun_q;
    rdreq_d    = '0;
    done_d     = 1'b0;

    head_ext = '0;
    head_ext[BIT_WIDTH-1:0] = fifo_q[int'(mic_q)*BIT_WIDTH +: BIT_WIDTH];
    head_empty = fifo_rdempty[mic_q];

    // First byte of a sample comes straight from the FIFO head; later bytes from the snapshot.
    if (bidx_q == 1'b0) begin
      cur_snap = head_empty ? '0 : head_ext;
      cur_vld  = ~head_empty;
    end else begin
      cur_snap = snap_q;
      cur_vld  = snap_vld_q;
    end
    out_byte = 8'(cur_snap >> (8 * (BPS - 1 - int'(bidx_q))));

    if (sync_fall) begin
      dout_d     = FRAME_SYNC;
      csum_d     = 8'h00;
      underrun_d = '0;
      state_d    = ST_SEQ;
    end else if (sync_rise) begin
      state_d = ST_IDLE;
    end else if (dn_edge) begin
      case (state_q)
        ST_SEQ: begin
          dout_d  = seq_q;
          csum_d  = seq_q;
          mic_d   = '0;
          bidx_d  = 1'b0;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          if (bidx_q == 1'b0) begin
            snap_d     = cur_snap;
            snap_vld_d = cur_vld;
            if (head_empty) underrun_d[mic_q] = 1'b1;
          end
          dout_d = out_byte;
          csum_d = csum_q ^ out_byte;
          if (bidx_q == LAST_BIDX) begin
            if (cur_vld) rdreq_d[mic_q] = 1'b1;
            bidx_d = 1'b0;
            if (mic_q == LAST_MIC) state_d = ST_CHK;
            else                   mic_d   = mic_q + 1'b1;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
        ST_CHK: begin
          dout_d  = csum_q;
          done_d  = 1'b1;
          seq_d   = seq_q + 8'h01;
          state_d = ST_SYNC;
        end
        ST_SYNC: begin
          dout_d     = FRAME_SYNC;
          csum_d     = 8'h00;
          underrun_d = '0;
          state_d    = ST_SEQ;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mic_q      <= '0;
      bidx_q     <= 1'b0;
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
      csum_q     <= 8'h00;
      seq_q      <= 8'h00;
      dout_q     <= 8'h00;
      rdreq_q    <= '0;
      underrun_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mic_q      <= mic_d;
      bidx_q     <= bidx_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
      csum_q     <= csum_d;
      seq_q      <= seq_d;
      dout_q     <= dout_d;
      rdreq_q    <= rdreq_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
    end
  end

  assign data_to_send = dout_q;
  assign fifo_rdreq   = rdreq_q;
  assign underrun     = underrun_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Bench for pcm_frame_packer: a 9x8-bit instance and a 2x12-bit instance driven from queue-modelled FIFOs.
// Expected frames are built from the FIFO contents: sync, seq, samples MSB byte first, XOR checksum.
module tb_pcm_frame_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        ssel_a, dn_a, done_a;
  logic [8:0]  empty_a, rdreq_a, und_a;
  logic [71:0] q_a;
  logic [7:0]  dout_a;

  logic        ssel_b, dn_b, done_b;
  logic [1:0]  empty_b, rdreq_b, und_b;
  logic [23:0] q_b;
  logic [7:0]  dout_b;

  pcm_frame_packer #(.NUM_MICS(9), .BIT_WIDTH(8), .FRAME_SYNC(8'hA5)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ssel(ssel_a), .data_needed(dn_a),
    .fifo_rdempty(empty_a), .fifo_q(q_a), .fifo_rdreq(rdreq_a),
    .data_to_send(dout_a), .underrun(und_a), .frame_done(done_a));

  pcm_frame_packer #(.NUM_MICS(2), .BIT_WIDTH(12), .FRAME_SYNC(8'hA5)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ssel(ssel_b), .data_needed(dn_b),
    .fifo_rdempty(empty_b), .fifo_q(q_b), .fifo_rdreq(rdreq_b),
    .data_to_send(dout_b), .underrun(und_b), .frame_done(done_b));

  logic [7:0]  qa [0:8][$];
  logic [11:0] qb [0:1][$];
  int checks = 0;
  int errors = 0;
  int gap = 2;
  logic [8:0] prev_rq_a = '0;
  logic [1:0] prev_rq_b = '0;
  logic [7:0] seq_a = 8'h00;
  logic [7:0] seq_b = 8'h00;
  logic [7:0] last_a = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int m = 0; m < 9; m++) begin
      empty_a[m]     = (qa[m].size() == 0);
      q_a[m*8 +: 8]  = (qa[m].size() != 0) ? qa[m][0] : 8'hEE;
    end
    for (int m = 0; m < 2; m++) begin
      empty_b[m]       = (qb[m].size() == 0);
      q_b[m*12 +: 12]  = (qb[m].size() != 0) ? qb[m][0] : 12'hEEE;
    end
  endtask

  // One clock; FIFO models pop on any observed strobe.
  task automatic cyc();
    @(posedge clk); #1;
    if (rdreq_a != 0) begin
      chk("rdreq_a_shape", ((rdreq_a & prev_rq_a) == 0) && $onehot(rdreq_a), 1);
      for (int m = 0; m < 9; m++) if (rdreq_a[m]) begin
        chk("pop_a_nonempty", qa[m].size() != 0, 1);
        if (qa[m].size() != 0) void'(qa[m].pop_front());
      end
    end
    prev_rq_a = rdreq_a;
    if (rdreq_b != 0) begin
      chk("rdreq_b_shape", ((rdreq_b & prev_rq_b) == 0) && $onehot(rdreq_b), 1);
      for (int m = 0; m < 2; m++) if (rdreq_b[m]) begin
        chk("pop_b_nonempty", qb[m].size() != 0, 1);
        if (qb[m].size() != 0) void'(qb[m].pop_front());
      end
    end
    prev_rq_b = rdreq_b;
    refresh();
  endtask

  task automatic edge_a(output logic [7:0] d, output logic [8:0] rq, output logic dn, output logic [8:0] u);
    dn_a = 1'b1; cyc();
    d = dout_a; rq = rdreq_a; dn = done_a; u = und_a; last_a = dout_a;
    dn_a = 1'b0; repeat (gap) cyc();
  endtask

  task automatic edge_b(output logic [7:0] d, output logic [1:0] rq, output logic dn, output logic [1:0] u);
    dn_b = 1'b1; cyc();
    d = dout_b; rq = rdreq_b; dn = done_b; u = und_b;
    dn_b = 1'b0; repeat (gap) cyc();
  endtask

  task automatic fill_a(input int empty_pct);
    for (int m = 0; m < 9; m++) begin
      qa[m].delete();
      if ($urandom_range(99) >= empty_pct) begin
        qa[m].push_back(8'($urandom));
        qa[m].push_back(8'($urandom));
      end
    end
    refresh();
  endtask

  task automatic fill_b(input int empty_pct);
    for (int m = 0; m < 2; m++) begin
      qb[m].delete();
      if ($urandom_range(99) >= empty_pct) begin
        qb[m].push_back(12'($urandom));
        qb[m].push_back(12'($urandom));
      end
    end
    refresh();
  endtask

  task automatic a_fall();
    ssel_a = 1'b0;
    repeat (3) cyc();
    chk("a_fall_sync", dout_a, 8'hA5);
    chk("a_fall_und", und_a, 0);
    last_a = dout_a;
  endtask

  task automatic b_fall();
    ssel_b = 1'b0;
    repeat (3) cyc();
    chk("b_fall_sync", dout_b, 8'hA5);
  endtask

  // From SEQ: seq byte, payload, checksum. stop_after>=0 stops after that many payload bytes.
  task automatic a_body(input int stop_after, output logic [7:0] ck);
    logic [7:0] d, e, cs;
    logic [8:0] rq, u, uexp;
    logic dn, full;
    ck = 8'h00; uexp = '0;
    edge_a(d, rq, dn, u);
    chk("a_seq", d, seq_a); chk("a_seq_done", dn, 0); chk("a_seq_rq", rq, 0);
    cs = seq_a;
    for (int m = 0; m < 9; m++) begin
      if (m == stop_after) return;
      full = (qa[m].size() != 0);
      e = full ? qa[m][0] : 8'h00;
      edge_a(d, rq, dn, u);
      if (!full) uexp[m] = 1'b1;
      chk("a_data", d, e);
      chk("a_pop", rq, full ? (9'b1 << m) : 9'b0);
      chk("a_underrun", u, uexp);
      chk("a_data_done", dn, 0);
      cs = cs ^ e;
    end
    edge_a(d, rq, dn, u);
    chk("a_csum", d, cs); chk("a_done", dn, 1); chk("a_csum_rq", rq, 0); chk("a_csum_und", u, uexp);
    ck = d;
    seq_a = seq_a + 8'h01;
  endtask

  task automatic a_resync();
    logic [7:0] d; logic [8:0] rq, u; logic dn;
    edge_a(d, rq, dn, u);
    chk("a_resync", d, 8'hA5); chk("a_resync_und", u, 0); chk("a_resync_done", dn, 0);
  endtask

  task automatic b_body(input int stop_after, output logic [7:0] ck);
    logic [7:0] d, e, cs;
    logic [1:0] rq, u, uexp;
    logic dn, full;
    logic [11:0] h;
    ck = 8'h00; uexp = '0;
    edge_b(d, rq, dn, u);
    chk("b_seq", d, seq_b); chk("b_seq_done", dn, 0);
    cs = seq_b;
    for (int m = 0; m < 2; m++) begin
      full = (qb[m].size() != 0);
      h = full ? qb[m][0] : 12'h000;
      if (!full) uexp[m] = 1'b1;
      for (int bb = 0; bb < 2; bb++) begin
        if (m*2 + bb == stop_after) return;
        e = (bb == 0) ? {4'h0, h[11:8]} : h[7:0];
        edge_b(d, rq, dn, u);
        chk("b_data", d, e);
        chk("b_pop", rq, (bb == 1 && full) ? (2'b01 << m) : 2'b00);
        chk("b_underrun", u, uexp);
        cs = cs ^ e;
      end
    end
    edge_b(d, rq, dn, u);
    chk("b_csum", d, cs); chk("b_done", dn, 1); chk("b_csum_rq", rq, 0);
    ck = d;
    seq_b = seq_b + 8'h01;
  endtask

  task automatic b_resync();
    logic [7:0] d; logic [1:0] rq, u; logic dn;
    edge_b(d, rq, dn, u);
    chk("b_resync", d, 8'hA5); chk("b_resync_und", u, 0);
  endtask

  initial begin
    logic [7:0] ck, hold, head4, d;
    logic [8:0] rq, u;
    logic dn;
    logic [11:0] head0;

    rst_n = 1'b0; ssel_a = 1'b1; ssel_b = 1'b1; dn_a = 1'b0; dn_b = 1'b0;
    refresh();
    repeat (3) cyc();
    chk("rst_dout_a", dout_a, 0); chk("rst_rdreq_a", rdreq_a, 0);
    chk("rst_und_a", und_a, 0);   chk("rst_done_a", done_a, 0);
    chk("rst_dout_b", dout_b, 0); chk("rst_rdreq_b", rdreq_b, 0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // Full frame with heads 0x10+m.
    for (int m = 0; m < 9; m++) begin
      qa[m].delete(); qa[m].push_back(8'h10 + 8'(m)); qa[m].push_back(8'($urandom));
    end
    refresh();
    a_fall();
    a_body(-1, ck);
    chk("a_spec_csum", ck, 8'h18);
    a_resync();

    // Underrun on mic 3 (seq is 1 here).
    for (int m = 0; m < 9; m++) begin
      qa[m].delete();
      if (m != 3) qa[m].push_back(8'h10 + 8'(m));
    end
    refresh();
    a_body(-1, ck);
    chk("a_spec_und_csum", ck, 8'h0B ^ 8'h01);
    chk("a_spec_und_mask", und_a, 9'h008);
    a_resync();

    repeat (6) begin
      fill_a(20);
      a_body(-1, ck);
      a_resync();
    end

    // Abort after 4 payload bytes, with the rise coinciding with a data_needed edge.
    fill_a(0);
    head4 = qa[4][0];
    a_body(4, ck);
    hold = last_a;
    ssel_a = 1'b1;
    cyc(); cyc();
    dn_a = 1'b1; cyc();
    chk("abort_coincident_hold", dout_a, hold);
    chk("abort_coincident_rq", rdreq_a, 0);
    dn_a = 1'b0; repeat (2) cyc();
    edge_a(d, rq, dn, u);
    chk("idle_edge_hold", d, hold); chk("idle_edge_rq", rq, 0);
    chk("abort_mic4_unpopped", qa[4][0], head4);
    a_fall();
    a_body(-1, ck);
    a_resync();

    // 12-bit samples on the 2-mic instance.
    qb[0].delete(); qb[0].push_back(12'hABC); qb[0].push_back(12'($urandom));
    qb[1].delete(); qb[1].push_back(12'h123); qb[1].push_back(12'($urandom));
    refresh();
    b_fall();
    b_body(-1, ck);
    chk("b_spec_csum", ck, 8'h94);
    b_resync();
    repeat (4) begin
      fill_b(25);
      b_body(-1, ck);
      b_resync();
    end
    fill_b(0);
    head0 = qb[0][0];
    b_body(1, ck);
    ssel_b = 1'b1;
    repeat (4) cyc();
    chk("b_abort_unpopped", qb[0][0], head0);
    b_fall();
    b_body(-1, ck);

    // Sequence wrap over 257 frames at minimum edge spacing.
    gap = 1;
    repeat (257) begin
      fill_a(10);
      a_body(-1, ck);
      a_resync();
    end
    gap = 2;

    // Reset during DATA with a pending underrun.
    fill_a(0);
    qa[1].delete();
    refresh();
    a_body(3, ck);
    chk("pre_reset_und", und_a, 9'h002);
    #2;
    rst_n = 1'b0; ssel_a = 1'b1; ssel_b = 1'b1;
    #1;
    chk("midrst_dout_a", dout_a, 0); chk("midrst_rdreq_a", rdreq_a, 0);
    chk("midrst_und_a", und_a, 0);   chk("midrst_done_a", done_a, 0);
    chk("midrst_dout_b", dout_b, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    seq_a = 8'h00; seq_b = 8'h00;
    cyc();
    repeat (2) begin
      edge_a(d, rq, dn, u);
      chk("post_rst_ignored", d, 0); chk("post_rst_rq", rq, 0);
    end
    a_fall();
    a_body(-1, ck);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
